// File: rtl/regarb_pkg.sv
// ----------------------------------------------------------------------------
// regarb_pkg
// Shared constants and types for the register-file write arbiter and its
// round-robin selector.
//   DEF_DATA_W / DEF_ADDR_W : default write data / register address widths
//   XZR_ADDR                : architectural zero register
//   arb_state_t             : arbiter FSM state (ARB, LOCKED)
//   lock_cnt_w()            : width of a beat counter that can hold lock_max
// ----------------------------------------------------------------------------
package regarb_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_ADDR_W = 5;

    localparam logic [4:0] XZR_ADDR = 5'd31;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // LOCK_CNT_W = $clog2(LOCK_MAX+1); a function because LOCK_MAX is a
    // parameter of the instantiating module, not of the package.
    function automatic int lock_cnt_w(input int lock_max);
        return $clog2(lock_max + 1);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches upward starting at the entry
// after ptr, wrapping modulo N, and picks the first requester that is active
// and not masked out by excl.
// Ports:
//   req   [N-1:0]    request vector
//   ptr   [IW-1:0]   index of the most recently served requester
//   excl  [N-1:0]    requesters barred from this pick
//   gnt   [N-1:0]    one-hot grant (all zero when nothing eligible)
//   idx   [IW-1:0]   index of the granted requester (0 when none)
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  excl,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [N-1:0] eligible;
    logic         found;
    int           cand;

    assign eligible = req & ~excl;

    // NOTE: every output of a combinational block gets a default at the top;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && eligible[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the register-file write port among NUM_REQ writers. Round-robin
// arbitration with locked multi-beat bursts bounded by LOCK_MAX beats; the
// winning request is registered onto wren/waddr/wdata one cycle later.
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   req       per-requester write request
//   req_lock  per-requester request to keep the grant next cycle
//   req_addr  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data  packed write data, requester i at [i*DATA_W +: DATA_W]
//   gnt       one-hot grant, combinational from req and state
//   wren      registered register-file write enable
//   waddr     registered register-file write address
//   wdata     registered register-file write data
//   busy      high while a lock is held
// Build option:
//   REGARB_XZR_FILTER_EN  transfers to XZR complete but never raise wren
// ----------------------------------------------------------------------------
module regfile_write_arbiter
    import regarb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int LOCK_MAX = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      wren,
    output logic [ADDR_W-1:0]         waddr,
    output logic [DATA_W-1:0]         wdata,
    output logic                      busy
);

    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LOCK_CNT_W = lock_cnt_w(LOCK_MAX);
    localparam logic [LOCK_CNT_W-1:0] BEAT_LAST = LOCK_CNT_W'(LOCK_MAX);

    arb_state_t              state;
    logic [IDX_W-1:0]        owner;
    logic [IDX_W-1:0]        rr_ptr;
    logic [LOCK_CNT_W-1:0]   beat_cnt;
    logic [LOCK_CNT_W-1:0]   beat_next;
    logic [NUM_REQ-1:0]      excl;

    logic [NUM_REQ-1:0]      pick_gnt;
    logic [IDX_W-1:0]        pick_idx;
    logic [IDX_W-1:0]        xfer_idx;
    logic                    xfer;
    logic                    wr_next;
    logic [ADDR_W-1:0]       xfer_addr;
    logic [DATA_W-1:0]       xfer_data;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req  (req),
        .ptr  (rr_ptr),
        .excl (excl),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    // While locked the owner is the only candidate; if it drops req the
    // cycle passes with no grant and the lock is released.
    always_comb begin
        gnt = '0;
        if (!reset) begin
            gnt = '0;
        end else if (state == LOCKED) begin
            if (req[owner]) gnt[owner] = 1'b1;
        end else begin
            gnt = pick_gnt;
        end
    end

    assign xfer      = |gnt;
    assign xfer_idx  = (state == LOCKED) ? owner : pick_idx;
    assign xfer_addr = req_addr[xfer_idx*ADDR_W +: ADDR_W];
    assign xfer_data = req_data[xfer_idx*DATA_W +: DATA_W];
    assign beat_next = beat_cnt + LOCK_CNT_W'(1);
    assign busy      = (state == LOCKED);

`ifdef REGARB_XZR_FILTER_EN
    // XZR writes are consumed here so the register file never sees them.
    assign wr_next = xfer && (xfer_addr != ADDR_W'(XZR_ADDR));
`else
    assign wr_next = xfer;
`endif

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ARB;
            owner    <= '0;
            rr_ptr   <= IDX_W'(NUM_REQ - 1);
            beat_cnt <= '0;
            excl     <= '0;
            wren     <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
        end else begin
            wren <= wr_next;
            if (xfer) begin
                waddr <= xfer_addr;
                wdata <= xfer_data;
            end
            // The exclusion after a LOCK_MAX exit lasts a single cycle.
            excl <= '0;
            case (state)
                ARB: begin
                    if (xfer) begin
                        rr_ptr <= pick_idx;
                        if (req_lock[pick_idx]) begin
                            if (LOCK_MAX == 1) begin
                                // First beat already exhausts the lock.
                                excl <= pick_gnt;
                            end else begin
                                state    <= LOCKED;
                                owner    <= pick_idx;
                                beat_cnt <= LOCK_CNT_W'(1);
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (!req[owner]) begin
                        state    <= ARB;
                        beat_cnt <= '0;
                    end else if (!req_lock[owner]) begin
                        state    <= ARB;
                        beat_cnt <= '0;
                    end else if (beat_next == BEAT_LAST) begin
                        state    <= ARB;
                        beat_cnt <= '0;
                        excl     <= gnt;
                    end else begin
                        beat_cnt <= beat_next;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Self-checking bench for regfile_write_arbiter (NUM_REQ=2, LOCK_MAX=4).
// A vector table supplies per-cycle inputs with the expected grant and busy;
// each expected transfer is queued and compared against wren/waddr/wdata in
// the following cycle. Reset-during-lock is a hand-written sequence.
// ----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    localparam int NR = 2;
    localparam int DW = 64;
    localparam int AW = 5;

    logic             clk;
    logic             reset;
    logic [NR-1:0]    req;
    logic [NR-1:0]    req_lock;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    gnt;
    logic             wren;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;
    logic             busy;

    regfile_write_arbiter #(
        .NUM_REQ  (NR),
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .LOCK_MAX (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_lock (req_lock),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .wren     (wren),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  lock;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [63:0] d0;
        logic [63:0] d1;
        logic [1:0]  gnt;
        logic        busy;
    } vec_t;

    typedef struct {
        logic        xfer;
        logic        wren;
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;

    localparam int NV = 28;
    vec_t tbl [NV];
    wr_t  sbq [$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic vec_t v(input logic [1:0] r, input logic [1:0] l,
                               input logic [4:0] a0, input logic [4:0] a1,
                               input logic [63:0] d0, input logic [63:0] d1,
                               input logic [1:0] g, input logic b);
        vec_t x;
        x.req = r; x.lock = l; x.a0 = a0; x.a1 = a1;
        x.d0 = d0; x.d1 = d1; x.gnt = g; x.busy = b;
        return x;
    endfunction

    // Compare registered write outputs against the transfer queued last cycle.
    task automatic check_write(input string tag);
        wr_t e;
        if (sbq.size() == 0) begin
            check({tag, ".wren_idle"}, 64'(wren), 64'd0);
        end else begin
            e = sbq.pop_front();
            check({tag, ".wren"}, 64'(wren), 64'(e.wren));
            if (e.xfer) begin
                check({tag, ".waddr"}, 64'(waddr), 64'(e.addr));
                check({tag, ".wdata"}, wdata, e.data);
            end
        end
    endtask

    task automatic step(input string tag, input vec_t s);
        wr_t e;
        check_write(tag);
        req      = s.req;
        req_lock = s.lock;
        req_addr = {s.a1, s.a0};
        req_data = {s.d1, s.d0};
        #1;
        check({tag, ".gnt"},  64'(gnt),  64'(s.gnt));
        check({tag, ".busy"}, 64'(busy), 64'(s.busy));
        e.xfer = (s.gnt != 2'b00);
        e.addr = s.gnt[1] ? s.a1 : s.a0;
        e.data = s.gnt[1] ? s.d1 : s.d0;
`ifdef REGARB_XZR_FILTER_EN
        e.wren = e.xfer && (e.addr != 5'd31);
`else
        e.wren = e.xfer;
`endif
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Defaults: requester 0 -> r3, requester 1 -> r7.
        tbl[0]  = v(2'b01, 2'b00, 5'd3,  5'd7,  64'hAAAA, 64'h5555, 2'b01, 1'b0);
        tbl[1]  = v(2'b00, 2'b00, 5'd3,  5'd7,  64'hAAAA, 64'h5555, 2'b00, 1'b0);
        tbl[2]  = v(2'b00, 2'b00, 5'd3,  5'd7,  64'hAAAA, 64'h5555, 2'b00, 1'b0);
        // Requester 1 locks against a contending requester 0; capped at 4 beats.
        tbl[3]  = v(2'b11, 2'b10, 5'd4,  5'd8,  64'h10,   64'h20,   2'b10, 1'b0);
        tbl[4]  = v(2'b11, 2'b10, 5'd4,  5'd8,  64'h10,   64'h21,   2'b10, 1'b1);
        tbl[5]  = v(2'b11, 2'b10, 5'd4,  5'd8,  64'h10,   64'h22,   2'b10, 1'b1);
        tbl[6]  = v(2'b11, 2'b10, 5'd4,  5'd8,  64'h10,   64'h23,   2'b10, 1'b1);
        tbl[7]  = v(2'b11, 2'b10, 5'd4,  5'd8,  64'h10,   64'h24,   2'b01, 1'b0);
        tbl[8]  = v(2'b11, 2'b10, 5'd4,  5'd8,  64'h11,   64'h24,   2'b10, 1'b0);
        tbl[9]  = v(2'b01, 2'b00, 5'd4,  5'd8,  64'h11,   64'h25,   2'b00, 1'b1);
        // Plain round robin, no lock.
        tbl[10] = v(2'b11, 2'b00, 5'd1,  5'd2,  64'hA1,   64'hB1,   2'b01, 1'b0);
        tbl[11] = v(2'b11, 2'b00, 5'd1,  5'd2,  64'hA2,   64'hB1,   2'b10, 1'b0);
        tbl[12] = v(2'b11, 2'b00, 5'd1,  5'd2,  64'hA2,   64'hB2,   2'b01, 1'b0);
        tbl[13] = v(2'b11, 2'b00, 5'd1,  5'd2,  64'hA3,   64'hB2,   2'b10, 1'b0);
        // Requester 0 locks two beats, releases, requester 1 goes next.
        tbl[14] = v(2'b11, 2'b01, 5'd5,  5'd6,  64'hC0,   64'hD0,   2'b01, 1'b0);
        tbl[15] = v(2'b11, 2'b00, 5'd5,  5'd6,  64'hC1,   64'hD0,   2'b01, 1'b1);
        tbl[16] = v(2'b11, 2'b00, 5'd5,  5'd6,  64'hC2,   64'hD0,   2'b10, 1'b0);
        // Address collision: both target r9, serialized in grant order.
        tbl[17] = v(2'b11, 2'b00, 5'd9,  5'd9,  64'hE0,   64'hF0,   2'b01, 1'b0);
        tbl[18] = v(2'b11, 2'b00, 5'd9,  5'd9,  64'hE1,   64'hF0,   2'b10, 1'b0);
        // Lone requester hits LOCK_MAX: one idle cycle with no grant.
        tbl[19] = v(2'b01, 2'b01, 5'd10, 5'd0,  64'h100,  64'h0,    2'b01, 1'b0);
        tbl[20] = v(2'b01, 2'b01, 5'd11, 5'd0,  64'h101,  64'h0,    2'b01, 1'b1);
        tbl[21] = v(2'b01, 2'b01, 5'd12, 5'd0,  64'h102,  64'h0,    2'b01, 1'b1);
        tbl[22] = v(2'b01, 2'b01, 5'd13, 5'd0,  64'h103,  64'h0,    2'b01, 1'b1);
        tbl[23] = v(2'b01, 2'b01, 5'd14, 5'd0,  64'h104,  64'h0,    2'b00, 1'b0);
        tbl[24] = v(2'b01, 2'b00, 5'd14, 5'd0,  64'h104,  64'h0,    2'b01, 1'b0);
        // Write to XZR.
        tbl[25] = v(2'b10, 2'b00, 5'd0,  5'd31, 64'h0,    64'hDEAD, 2'b10, 1'b0);
        tbl[26] = v(2'b00, 2'b00, 5'd0,  5'd31, 64'h0,    64'hDEAD, 2'b00, 1'b0);
        tbl[27] = v(2'b00, 2'b00, 5'd0,  5'd31, 64'h0,    64'hDEAD, 2'b00, 1'b0);

        // Reset state, with requests present to show gnt is forced low.
        reset    = 1'b0;
        req      = 2'b11;
        req_lock = 2'b00;
        req_addr = '0;
        req_data = '0;
        #12;
        check("rst.gnt",   64'(gnt),   64'd0);
        check("rst.wren",  64'(wren),  64'd0);
        check("rst.waddr", 64'(waddr), 64'd0);
        check("rst.wdata", wdata,      64'd0);
        check("rst.busy",  64'(busy),  64'd0);
        @(negedge clk);
        req   = 2'b00;
        reset = 1'b1;

        for (int i = 0; i < NV; i++) step($sformatf("v%0d", i), tbl[i]);
        check_write("drain");

        // Reset mid-lock, one cycle after a transfer.
        req      = 2'b01;
        req_lock = 2'b01;
        req_addr = {5'd0, 5'd12};
        req_data = {64'h0, 64'hBEEF};
        #1;
        check("lk.gnt", 64'(gnt), 64'h1);
        @(posedge clk);
        #1;
        check("lk.wren",  64'(wren),  64'd1);
        check("lk.waddr", 64'(waddr), 64'd12);
        check("lk.busy",  64'(busy),  64'd1);
        reset = 1'b0;
        #1;
        check("rstlk.wren", 64'(wren), 64'd0);
        check("rstlk.busy", 64'(busy), 64'd0);
        check("rstlk.gnt",  64'(gnt),  64'd0);
        sbq.delete();
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step("post_rst0", v(2'b11, 2'b00, 5'd20, 5'd21, 64'h77, 64'h88, 2'b01, 1'b0));
        step("post_rst1", v(2'b00, 2'b00, 5'd20, 5'd21, 64'h77, 64'h88, 2'b00, 1'b0));
        check_write("post_rst_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the register file (a bank of write-enabled registers, one per architectural register) among NUM_REQ writers, e.g. pipeline writeback and the multi-cycle load/multiply return path.
- Arbitrates round-robin and supports locked multi-beat bursts (e.g. load-pair writing two registers back-to-back).
- Drives a registered wren/waddr/wdata into the register-file write decoder.

Parameters:
- NUM_REQ, 2, number of write requesters (2..4).
- DATA_W, 64, write data width.
- ADDR_W, 5, register address width.
- LOCK_MAX, 4, maximum consecutive beats one requester may hold a lock (>=1).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester write request.
- req_lock  input  NUM_REQ  request to keep the grant on the following cycle.
- req_addr  input  NUM_REQ*ADDR_W  packed destination addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  packed write data, same packing.
- gnt  output  NUM_REQ  one-hot grant; combinational from current req and state.
- wren  output  1  register-file write enable, registered.
- waddr  output  ADDR_W  register-file write address, registered.
- wdata  output  DATA_W  register-file write data, registered.
- busy  output  1  high while in LOCKED state.

Behaviour:
- Reset (reset low, asynchronous): wren=0, waddr=0, wdata=0, busy=0, state=IDLE, beat count=0, rr pointer=NUM_REQ-1 (requester 0 has first priority). gnt=0 while reset is low.
- Handshake:
  - Requester holds req, addr and data stable until it samples gnt high at a rising edge; that edge is the transfer.
  - Dropping req without a grant is legal; nothing is written.
- Latency: transfer at edge N -> wren/waddr/wdata valid for cycle N..N+1 -> register file captures at edge N+1. Exactly one write per transfer; wren=0 in any cycle with no transfer at the previous edge.
- States:
  - IDLE/ARB:
    - Search starts at the requester after the rr pointer and wraps modulo NUM_REQ; the first requester with req=1 is granted.
    - On transfer, pointer := granted index.
    - If req_lock of the granted requester =1 -> LOCKED, beat count=1.
  - LOCKED:
    - Grant is forced to the lock owner if its req=1; other requesters get gnt=0.
    - Each transfer increments beat count.
    - Exit to ARB when the owner's req=0, when it transfers with req_lock=0, or when beat count reaches LOCK_MAX.
    - On a LOCK_MAX exit, the owner is excluded from arbitration for exactly one cycle. If no other requester is active, no grant is issued that cycle.
    - busy=1.
- Simultaneous requests: round-robin order only; no fixed priority beyond the reset pointer.
- Address collision (two requesters targeting the same register): serialized in grant order; the last write wins.
- Reset asserted mid-burst: lock abandoned, pending registered write dropped (wren forced 0 asynchronously).
- NUM_REQ=1: gnt mirrors req; lock still bounded by LOCK_MAX.

Optional Feature:
- Macro REGARB_XZR_FILTER_EN.
- Defined: a transfer with addr == 31 (XZR) is granted and completes normally but produces wren=0 in the following cycle; waddr/wdata still update.
- Undefined: address 31 is written like any other; the register file handles XZR itself.

Decomposition:
- Package regarb_pkg:
  - default DATA_W/ADDR_W constants
  - XZR_ADDR = 5'd31
  - state enum {ARB, LOCKED}
  - LOCK_CNT_W = $clog2(LOCK_MAX+1)
- Sub-module rr_pick: combinational round-robin selector (inputs: request vector, pointer, exclude mask; outputs: one-hot grant and index). It is reusable for a future register-file read-port arbiter.

Test Plan:
- Reset release, req=01, addr0=3, data0=0xAAAA -> gnt=01 same cycle; next cycle wren=1, waddr=3, wdata=0xAAAA; then wren=0.
- req=11 held for 4 cycles, no lock -> gnt sequence 01,10,01,10; waddr alternates between the two requesters' addresses.
- Requester 1 req=1 and req_lock=1 for 6 cycles, requester 0 req=1 throughout, LOCK_MAX=4 -> gnt=10 for 4 cycles, busy=1, then gnt=01 for one cycle, then requester 1 wins arbitration again.
- Lock by requester 0 for 2 beats, then req_lock=0 on beat 2 -> returns to ARB after beat 2; the next grant goes to requester 1 if it is requesting.
- reset pulsed low mid-lock, one cycle after a transfer -> wren drops immediately; after release, state=ARB and requester 0 has priority.
- With REGARB_XZR_FILTER_EN, a transfer with addr=31 -> gnt=1, wren stays 0 the next cycle; without the macro, wren=1 and waddr=31.
